universal_shift_register: RTL and testbench
===========================================

# universal_shift_register

Parametrised WIDTH-bit register with synchronous load, set, clear, shift and rotate operations, serial I/O on both ends, and complemented output. It adds a multi-cycle burst shift, which shifts or rotates by a programmable amount under a start/busy/done handshake. It replaces single-purpose D-register banks wherever a datapath needs serial conversion or bit-stepping.

## Interface
- WIDTH, 8, register width; must be at least 2
- RESET_VAL, {WIDTH{1'b0}}, value of q after reset
- CNT_W, $clog2(WIDTH+1), width of amount (derived, not overridden)

- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- en  in  1  operation enable; the op is ignored when low
- op  in  3  0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 SET, 7 CLR
- data  in  WIDTH  parallel load value
- ser_in_l  in  1  fill bit for SHL; enters at bit 0
- ser_in_r  in  1  fill bit for SHR; enters at bit WIDTH-1
- start  in  1  request a burst of the shift/rotate op
- amount  in  CNT_W  burst step count; values above WIDTH saturate to WIDTH
- q  out  WIDTH  register contents
- nq  out  WIDTH  ~q, combinational
- ser_out_l  out  1  q[WIDTH-1]
- ser_out_r  out  1  q[0]
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse when a burst completes

## Operation
- Reset (reset_n low at an edge) has highest priority. It sets q=RESET_VAL, busy=0 and done=0, and returns the FSM to IDLE from any state, including mid-burst.
- FSM states:
  - IDLE: single-step mode.
  - RUN: burst in progress; busy=1 exactly in RUN.
- IDLE with en=1, start=0: op is applied once per edge.
  - SHL: q <= {q[WIDTH-2:0], ser_in_l}
  - SHR: q <= {ser_in_r, q[WIDTH-1:1]}
  - ROL and ROR: rotate by 1.
  - SET: all ones.
  - CLR: all zeros.
  - LOAD: q <= data.
  - HOLD: no change.
- IDLE with en=0: q holds; start is ignored.
- IDLE with en=1, start=1, op in {SHL, SHR, ROL, ROR}:
  - The accept edge captures op and the saturated amount N. q is unchanged at the accept edge.
  - N>0: go to RUN with count=N.
  - N=0: stay in IDLE and pulse done on the next cycle.
- start=1 with op in {HOLD, LOAD, SET, CLR}: start is ignored and op executes as single-step.
- RUN, each edge:
  - Apply the captured op once; serial inputs are sampled live at each step edge.
  - Decrement count. When count reaches 0 → IDLE, and done=1 for that following cycle.
- RUN with en=1 and op SET or CLR (abort):
  - q is set or cleared at that edge.
  - FSM → IDLE, busy drops, and no done pulse is issued.
- RUN: all other en/op/start/data values are ignored, including start.
- Rotations never lose bits: ROL by WIDTH returns the original q.
- Shifts by WIDTH fully replace q with the serial-in bits.

## Timing
- Single-step: the result is visible on q one edge after the inputs are sampled. nq and ser_out follow q combinationally.
- Burst with N≥1, accept edge e0:
  - busy=1 from after e0 through eN.
  - After edge ek (1≤k≤N), q shows k steps.
  - After eN: busy=0 and done=1 for one cycle.
  - Total N+1 edges from accept to done.
- Back-to-back bursts: a new start is accepted in the cycle where done=1, since the FSM is in IDLE.
- done never coincides with busy=1.

## Structure
- Shared package usr_pkg holds:
  - op enum (usr_op_t) with the codes above.
  - State enum (IDLE, RUN).
  - Pure function usr_step(q, op, ser_in_l, ser_in_r), which returns the next value.
  - Function usr_clamp(amount, WIDTH).
- No sub-module. The single module contains the q register, the FSM, the count register and the captured-op register; single-step and burst paths share usr_step.

## Test plan
- Reset: WIDTH=8, RESET_VAL=8'hA5, reset_n low for one edge mid-burst → q=A5, busy=0, done=0 after that edge.
- Single-step: LOAD 8'h81, then SHL with ser_in_l=1 → 8'h03; SHR with ser_in_r=0 → 8'h01; ROR → 8'h80; nq=8'h7F.
- Burst: q=8'h96, ROL with start=1, amount=3 → busy for 3 cycles, q 2D, 5A, B4, then done=1 for one cycle and busy=0.
- Boundaries:
  - amount=0 → done pulse next cycle, q unchanged.
  - amount=15 with WIDTH=8 → 8 steps.
  - ROL by 8 → q unchanged.
  - SHL by 8 with ser_in_l=1 → 8'hFF.
- Abort: CLR with en=1 during a SHR burst → q=0 next edge, busy=0, no done; LOAD during RUN is ignored.
- Edge cases:
  - en=0 with start=1 → nothing happens.
  - start with op=LOAD → plain load, busy stays 0.
  - New start during the done cycle → new burst accepted.

Source files
------------

// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - shared op/state types and step/clamp helpers for universal_shift_register
package usr_pkg;

  localparam int USR_MAX_W = 64;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_LOAD = 3'd1,
    OP_SHL  = 3'd2,
    OP_SHR  = 3'd3,
    OP_ROL  = 3'd4,
    OP_ROR  = 3'd5,
    OP_SET  = 3'd6,
    OP_CLR  = 3'd7
  } usr_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } usr_state_t;

  // Operates on a zero-extended value so one function serves every WIDTH up to USR_MAX_W.
  // LOAD returns q unchanged; the caller substitutes the parallel data.
  function automatic logic [USR_MAX_W-1:0] usr_step(
    input logic [USR_MAX_W-1:0] q,
    input usr_op_t              op,
    input logic                 ser_in_l,
    input logic                 ser_in_r,
    input int                   width
  );
    logic [USR_MAX_W-1:0] mask;
    logic [USR_MAX_W-1:0] r;
    logic                 msb;
    msb = 1'b0;
    for (int i = 0; i < USR_MAX_W; i++) begin
      mask[i] = (i < width);
      if (i == width - 1) msb = q[i];
    end
    r = q;
    case (op)
      OP_SHL: r = {q[USR_MAX_W-2:0], ser_in_l};
      OP_ROL: r = {q[USR_MAX_W-2:0], msb};
      OP_SHR, OP_ROR: begin
        r = q >> 1;
        for (int i = 0; i < USR_MAX_W; i++)
          if (i == width - 1) r[i] = (op == OP_SHR) ? ser_in_r : q[0];
      end
      OP_SET:  r = '1;
      OP_CLR:  r = '0;
      default: r = q;
    endcase
    return r & mask;
  endfunction

  function automatic int unsigned usr_clamp(input int unsigned amount, input int unsigned width);
    return (amount > width) ? width : amount;
  endfunction

endpackage

// File: rtl/universal_shift_register.sv
// rtl/universal_shift_register.sv - WIDTH-bit load/set/clear/shift/rotate register with counted burst mode
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nq,
  output logic             ser_out_l,
  output logic             ser_out_r,
  output logic             busy,
  output logic             done
);

  usr_state_t       r_state, w_state_next;
  logic [WIDTH-1:0] r_q, w_q_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  usr_op_t          r_op, w_op_next;
  logic             r_done, w_done_next;

  usr_op_t          w_op_in;
  usr_op_t          w_step_op;
  logic [WIDTH-1:0] w_step;
  logic [CNT_W-1:0] w_amt;
  logic             w_is_shift;

  assign w_op_in    = usr_op_t'(op);
  assign w_step_op  = (r_state == ST_RUN) ? r_op : w_op_in;
  assign w_step     = WIDTH'(usr_step(USR_MAX_W'(r_q), w_step_op, ser_in_l, ser_in_r, WIDTH));
  assign w_amt      = CNT_W'(usr_clamp(32'(amount), WIDTH));
  assign w_is_shift = (w_op_in == OP_SHL) || (w_op_in == OP_SHR) ||
                      (w_op_in == OP_ROL) || (w_op_in == OP_ROR);

  always_comb begin
    w_state_next = r_state;
    w_q_next     = r_q;
    w_cnt_next   = r_cnt;
    w_op_next    = r_op;
    w_done_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (en) begin
          if (start && w_is_shift) begin
            // Accept edge: q is left alone, the op and clamped count are latched.
            w_op_next = w_op_in;
            if (w_amt == '0) begin
              w_done_next = 1'b1;
            end else begin
              w_state_next = ST_RUN;
              w_cnt_next   = w_amt;
            end
          end else if (w_op_in == OP_LOAD) begin
            w_q_next = data;
          end else begin
            w_q_next = w_step;
          end
        end
      end
      ST_RUN: begin
        if (en && ((w_op_in == OP_SET) || (w_op_in == OP_CLR))) begin
          w_q_next     = (w_op_in == OP_SET) ? '1 : '0;
          w_state_next = ST_IDLE;
        end else begin
          w_q_next   = w_step;
          w_cnt_next = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            w_state_next = ST_IDLE;
            w_done_next  = 1'b1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_q     <= RESET_VAL;
      r_cnt   <= '0;
      r_op    <= OP_HOLD;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_q     <= w_q_next;
      r_cnt   <= w_cnt_next;
      r_op    <= w_op_next;
      r_done  <= w_done_next;
    end
  end

  assign q         = r_q;
  assign nq        = ~r_q;
  assign ser_out_l = r_q[WIDTH-1];
  assign ser_out_r = r_q[0];
  assign busy      = (r_state == ST_RUN);
  assign done      = r_done;

endmodule

// File: tb/tb_universal_shift_register.sv
// tb/tb_universal_shift_register.sv - directed self-checking bench for universal_shift_register
module tb_universal_shift_register;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          en;
  logic [2:0]    op;
  logic [W-1:0]  data;
  logic          ser_in_l;
  logic          ser_in_r;
  logic          start;
  logic [CW-1:0] amount;
  logic [W-1:0]  q;
  logic [W-1:0]  nq;
  logic          ser_out_l;
  logic          ser_out_r;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3,
                         ROL  = 3'd4, ROR  = 3'd5, SET = 3'd6, CLR = 3'd7;

  universal_shift_register #(.WIDTH(W), .RESET_VAL(8'hA5)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .op(op), .data(data),
    .ser_in_l(ser_in_l), .ser_in_r(ser_in_r), .start(start), .amount(amount),
    .q(q), .nq(nq), .ser_out_l(ser_out_l), .ser_out_r(ser_out_r),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [2:0] o, input logic s, input logic [CW-1:0] a);
    en = e; op = o; start = s; amount = a;
  endtask

  task automatic load(input logic [W-1:0] v);
    drive(1'b1, LOAD, 1'b0, '0);
    data = v;
    step();
    drive(1'b0, HOLD, 1'b0, '0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b0, HOLD, 1'b0, '0);
    data = '0; ser_in_l = 1'b0; ser_in_r = 1'b0;
    step();
    step();
    checks++;
    if ({q, nq, busy, done} !== {8'hA5, 8'h5A, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: q=%h nq=%h busy=%b done=%b, want q=a5 nq=5a busy=0 done=0", q, nq, busy, done);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single_step();
    load(8'h81);
    checks++;
    if ({q, ser_out_l, ser_out_r} !== {8'h81, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL load: q=%h sol=%b sor=%b, want 81 1 1", q, ser_out_l, ser_out_r);
    end
    ser_in_l = 1'b1;
    drive(1'b1, SHL, 1'b0, '0);
    step();
    checks++;
    if (q !== 8'h03) begin
      errors++;
      $display("FAIL shl: q=%h want 03", q);
    end
    ser_in_r = 1'b0;
    drive(1'b1, SHR, 1'b0, '0);
    step();
    checks++;
    if (q !== 8'h01) begin
      errors++;
      $display("FAIL shr: q=%h want 01", q);
    end
    drive(1'b1, ROR, 1'b0, '0);
    step();
    checks++;
    if ({q, nq, ser_out_l, ser_out_r} !== {8'h80, 8'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ror: q=%h nq=%h sol=%b sor=%b, want 80 7f 1 0", q, nq, ser_out_l, ser_out_r);
    end
    drive(1'b1, SET, 1'b0, '0);
    step();
    drive(1'b1, ROL, 1'b0, '0);
    step();
    drive(1'b1, CLR, 1'b0, '0);
    step();
    checks++;
    if (q !== 8'h00) begin
      errors++;
      $display("FAIL set_rol_clr: q=%h want 00", q);
    end
  endtask

  task automatic test_burst();
    logic [W-1:0] exp_q [3];
    exp_q = '{8'h2D, 8'h5A, 8'hB4};
    load(8'h96);
    drive(1'b1, ROL, 1'b1, 4'd3);
    step();
    checks++;
    if ({q, busy, done} !== {8'h96, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL burst_accept: q=%h busy=%b done=%b, want 96 1 0", q, busy, done);
    end
    drive(1'b0, HOLD, 1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({q, busy, done} !== {exp_q[k], (k < 2), (k == 2)}) begin
        errors++;
        $display("FAIL burst_step%0d: q=%h busy=%b done=%b, want %h %b %b", k + 1, q, busy, done,
                 exp_q[k], (k < 2), (k == 2));
      end
    end
    step();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL burst_done_pulse: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_boundaries();
    int edges;
    load(8'h3C);
    drive(1'b1, ROL, 1'b1, 4'd0);
    step();
    drive(1'b0, HOLD, 1'b0, '0);
    checks++;
    if ({q, busy, done} !== {8'h3C, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL amount0: q=%h busy=%b done=%b, want 3c 0 1", q, busy, done);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL amount0_pulse: done=%b want 0", done);
    end

    load(8'h01);
    drive(1'b1, ROL, 1'b1, 4'd15);
    step();
    drive(1'b0, HOLD, 1'b0, '0);
    edges = 0;
    while (done !== 1'b1 && edges < 20) begin
      step();
      edges++;
    end
    checks++;
    if (edges !== 8 || q !== 8'h01) begin
      errors++;
      $display("FAIL amount15_rol8: edges=%0d q=%h, want 8 01", edges, q);
    end

    load(8'h00);
    ser_in_l = 1'b1;
    drive(1'b1, SHL, 1'b1, 4'd8);
    step();
    drive(1'b0, HOLD, 1'b0, '0);
    for (int k = 0; k < 8; k++) step();
    checks++;
    if ({q, busy, done} !== {8'hFF, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL shl8: q=%h busy=%b done=%b, want ff 0 1", q, busy, done);
    end
    ser_in_l = 1'b0;
    step();
  endtask

  task automatic test_abort();
    load(8'hF0);
    ser_in_r = 1'b0;
    drive(1'b1, SHR, 1'b1, 4'd5);
    step();
    data = 8'hAA;
    drive(1'b1, LOAD, 1'b0, '0);
    step();
    checks++;
    if ({q, busy} !== {8'h78, 1'b1}) begin
      errors++;
      $display("FAIL run_ignores_load: q=%h busy=%b, want 78 1", q, busy);
    end
    drive(1'b1, CLR, 1'b0, '0);
    step();
    drive(1'b0, HOLD, 1'b0, '0);
    checks++;
    if ({q, busy, done} !== {8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL abort_clr: q=%h busy=%b done=%b, want 00 0 0", q, busy, done);
    end
    step();
    checks++;
    if ({q, busy, done} !== {8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL abort_no_done: q=%h busy=%b done=%b, want 00 0 0", q, busy, done);
    end
  endtask

  task automatic test_edge_cases();
    load(8'h3C);
    drive(1'b0, SHL, 1'b1, 4'd3);
    step();
    step();
    checks++;
    if ({q, busy, done} !== {8'h3C, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL en0_start: q=%h busy=%b done=%b, want 3c 0 0", q, busy, done);
    end
    data = 8'h5A;
    drive(1'b1, LOAD, 1'b1, 4'd3);
    step();
    drive(1'b0, HOLD, 1'b0, '0);
    checks++;
    if ({q, busy, done} !== {8'h5A, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL start_with_load: q=%h busy=%b done=%b, want 5a 0 0", q, busy, done);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_q [3];
    exp_q = '{8'h02, 8'h01, 8'h80};
    load(8'h01);
    drive(1'b1, ROL, 1'b1, 4'd1);
    step();
    drive(1'b0, HOLD, 1'b0, '0);
    step();
    checks++;
    if ({q, busy, done} !== {exp_q[0], 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL b2b_first_done: q=%h busy=%b done=%b, want 02 0 1", q, busy, done);
    end
    drive(1'b1, ROR, 1'b1, 4'd2);
    step();
    drive(1'b0, HOLD, 1'b0, '0);
    checks++;
    if ({q, busy, done} !== {exp_q[0], 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_accept: q=%h busy=%b done=%b, want 02 1 0", q, busy, done);
    end
    step();
    step();
    checks++;
    if ({q, busy, done} !== {exp_q[2], 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL b2b_second_done: q=%h busy=%b done=%b, want 80 0 1", q, busy, done);
    end
  endtask

  task automatic test_reset_mid_burst();
    load(8'h12);
    drive(1'b1, ROL, 1'b1, 4'd5);
    step();
    drive(1'b0, HOLD, 1'b0, '0);
    step();
    checks++;
    if ({q, busy} !== {8'h24, 1'b1}) begin
      errors++;
      $display("FAIL pre_reset_step: q=%h busy=%b, want 24 1", q, busy);
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    checks++;
    if ({q, busy, done} !== {8'hA5, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_burst: q=%h busy=%b done=%b, want a5 0 0", q, busy, done);
    end
    step();
    checks++;
    if ({q, busy, done} !== {8'hA5, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL after_reset_idle: q=%h busy=%b done=%b, want a5 0 0", q, busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_burst();
    test_boundaries();
    test_abort();
    test_edge_cases();
    test_back_to_back();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
